// File: rtl/sr_drv_pkg.sv
// Shared definitions for sr_latch_driver: FSM state encoding, counter width,
// legal parameter limits and the counter reload helper.
// Latency: n/a (package). Backpressure: n/a (package).
//
// Contents:
//   sr_state_t       IDLE / PULSE / GUARD / VERIFY
//   CNT_W            width of the shared phase down-counter
//   PARAM_MIN/MAX    legal range of PULSE_W, GUARD_W and TIMEOUT
//   cnt_load()       reload value for a phase lasting w cycles
package sr_drv_pkg;

    localparam int CNT_W     = 8;
    localparam int PARAM_MIN = 1;
    localparam int PARAM_MAX = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        GUARD  = 2'd2,
        VERIFY = 2'd3
    } sr_state_t;

    // The counter is loaded on phase entry and the phase ends in the cycle it
    // reads zero, so a phase of w cycles loads w-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int w);
        return CNT_W'(w - 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous latch Q readback into clk.
// Latency: 2 clk cycles from a stable d to q.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk    in   sampling clock, rising edge
//   rst_n  in   asynchronous active-low reset, both flops clear to 0
//   d      in   asynchronous input
//   q      out  synchronised copy of d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// Drives one width-controlled S or R pulse per accepted request, then a guard gap.
// Latency: accept-to-done PULSE_W+GUARD_W+1 (no readback) or +1+k (readback match in VERIFY cycle k).
// Backpressure: req_ready low whenever busy; requests offered while busy are ignored, not queued.
//
// Optional feature macro: SR_DRV_VERIFY_EN
//   defined   - q_fb is synchronised and compared after the guard; err flags a timeout
//   undefined - no readback; q_fb unused, err tied low, done right after the guard
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_level  in   requested latch level (1 = set, 0 = reset)
//   req_ready  out  high in IDLE, request accepted on req_valid && req_ready
//   s_out      out  latch S input (flop driven)
//   r_out      out  latch R input (flop driven)
//   q_fb       in   latch Q output, asynchronous to clk
//   busy       out  high in any state other than IDLE
//   done       out  one-cycle completion pulse
//   err        out  readback timeout flag, sticky until the next accept
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int GUARD_W = 2,
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic s_out,
    output logic r_out,
    input  logic q_fb,
    output logic busy,
    output logic done,
    output logic err
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------
    if (PULSE_W < PARAM_MIN || PULSE_W > PARAM_MAX) begin : g_bad_pulse_w
        $error("sr_latch_driver: PULSE_W outside 1..255");
    end
    if (GUARD_W < PARAM_MIN || GUARD_W > PARAM_MAX) begin : g_bad_guard_w
        $error("sr_latch_driver: GUARD_W outside 1..255");
    end
    if (TIMEOUT < PARAM_MIN || TIMEOUT > PARAM_MAX) begin : g_bad_timeout
        $error("sr_latch_driver: TIMEOUT outside 1..255");
    end

    localparam logic [CNT_W-1:0] PULSE_LOAD = cnt_load(PULSE_W);
    localparam logic [CNT_W-1:0] GUARD_LOAD = cnt_load(GUARD_W);

    sr_state_t        state_r;
    sr_state_t        state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lvl_r;
    logic             lvl_nxt;
    logic             done_nxt;
    logic             s_nxt;
    logic             r_nxt;
    logic             cnt_zero;

    assign cnt_zero = (cnt_r == '0);

    // ------------------------------------------------------------------
    // Readback path (optional)
    // ------------------------------------------------------------------
`ifdef SR_DRV_VERIFY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = cnt_load(TIMEOUT);

    logic q_sync;
    logic err_r;
    logic err_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (q_fb),
        .q     (q_sync)
    );

    assign err = err_r;
`else
    // Without readback the latch output is not observed at all.
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign err         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        lvl_nxt   = lvl_r;
        done_nxt  = 1'b0;
`ifdef SR_DRV_VERIFY_EN
        err_nxt   = err_r;
`endif

        unique case (state_r)
            IDLE: begin
                // A request is always executed, even if the latch already
                // holds the requested level: it acts as a refresh pulse.
                if (req_valid) begin
                    lvl_nxt   = req_level;
                    state_nxt = PULSE;
                    cnt_nxt   = PULSE_LOAD;
`ifdef SR_DRV_VERIFY_EN
                    err_nxt   = 1'b0;
`endif
                end
            end

            PULSE: begin
                if (cnt_zero) begin
                    state_nxt = GUARD;
                    cnt_nxt   = GUARD_LOAD;
                end else begin
                    cnt_nxt = cnt_r - CNT_W'(1);
                end
            end

            GUARD: begin
                if (cnt_zero) begin
`ifdef SR_DRV_VERIFY_EN
                    state_nxt = VERIFY;
                    cnt_nxt   = TIMEOUT_LOAD;
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt_r - CNT_W'(1);
                end
            end

`ifdef SR_DRV_VERIFY_EN
            VERIFY: begin
                // A match wins over an expiring counter in the same cycle.
                if (q_sync == lvl_r) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_r - CNT_W'(1);
                end
            end
`endif

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // S and R are derived from the single next state and a single level
        // bit, so they can never be high together.
        s_nxt = (state_nxt == PULSE) &&  lvl_nxt;
        r_nxt = (state_nxt == PULSE) && !lvl_nxt;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            lvl_r   <= 1'b0;
            s_out   <= 1'b0;
            r_out   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            lvl_r   <= lvl_nxt;
            s_out   <= s_nxt;
            r_out   <= r_nxt;
            done    <= done_nxt;
        end
    end

`ifdef SR_DRV_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_nxt;
        end
    end
`endif

    assign req_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_sr_latch_driver.sv
`timescale 1ns/1ps
module tb_sr_latch_driver;

    localparam int P = 4;
    localparam int G = 2;
    localparam int T = 8;
`ifdef SR_DRV_VERIFY_EN
    localparam int DMIN   = P + G + 2;  // readback matches in VERIFY cycle 1
    localparam int DMIN_B = 1 + 1 + 2;
`else
    localparam int DMIN   = P + G + 1;  // done right after the last guard cycle
    localparam int DMIN_B = 1 + 1 + 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_level = 1'b0;
    logic q_fb = 1'b0;
    logic req_ready, s_out, r_out, busy, done, err;

    logic req_valid_b = 1'b0;
    logic req_level_b = 1'b0;
    logic q_fb_b = 1'b0;
    logic req_ready_b, s_out_b, r_out_b, busy_b, done_b, err_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sr_latch_driver #(.PULSE_W(P), .GUARD_W(G), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_level(req_level),
        .req_ready(req_ready), .s_out(s_out), .r_out(r_out), .q_fb(q_fb),
        .busy(busy), .done(done), .err(err)
    );

    sr_latch_driver #(.PULSE_W(1), .GUARD_W(1), .TIMEOUT(T)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_level(req_level_b),
        .req_ready(req_ready_b), .s_out(s_out_b), .r_out(r_out_b), .q_fb(q_fb_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // S and R must never be high together, sampled every cycle on both instances.
    always @(negedge clk) begin
        chk("no_s_and_r", 0, s_out && r_out, 1'b0);
        chk("no_s_and_r_b", 0, s_out_b && r_out_b, 1'b0);
    end

    // Called at a negedge: offers a request that the next posedge accepts
    // (cycle 0), then checks every cycle up to and including the done cycle.
    // hold keeps req_valid high (back-to-back); fb_cyc/fb_val change q_fb in
    // that cycle; poke_cyc offers a one-cycle opposite-level request while busy.
    task automatic run_req(input logic lvl, input int done_cyc, input logic exp_err,
                           input bit hold, input int fb_cyc, input logic fb_val,
                           input int poke_cyc);
        req_valid = 1'b1;
        req_level = lvl;
        for (int c = 1; c <= done_cyc; c++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (c == fb_cyc) q_fb = fb_val;
            chk("s_out", c, s_out, (c <= P) && lvl);
            chk("r_out", c, r_out, (c <= P) && !lvl);
            chk("busy", c, busy, c < done_cyc);
            chk("req_ready", c, req_ready, c >= done_cyc);
            chk("done", c, done, c == done_cyc);
            chk("err", c, err, (c == done_cyc) ? exp_err : 1'b0);
            if (poke_cyc > 0 && c == poke_cyc) begin
                req_valid = 1'b1;
                req_level = !lvl;
            end else if (poke_cyc > 0 && c == poke_cyc + 1) begin
                req_valid = 1'b0;
                req_level = lvl;
            end
        end
    endtask

    task automatic run_b(input logic lvl, input int done_cyc);
        req_valid_b = 1'b1;
        req_level_b = lvl;
        for (int c = 1; c <= done_cyc; c++) begin
            @(negedge clk);
            req_valid_b = 1'b0;
            chk("b_s_out", c, s_out_b, (c == 1) && lvl);
            chk("b_r_out", c, r_out_b, (c == 1) && !lvl);
            chk("b_busy", c, busy_b, c < done_cyc);
            chk("b_done", c, done_b, c == done_cyc);
            chk("b_err", c, err_b, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_out", 0, s_out, 1'b0);
        chk("rst_r_out", 0, r_out, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_done", 0, done, 1'b0);
        chk("rst_err", 0, err, 1'b0);
        chk("rst_req_ready", 0, req_ready, 1'b1);
        chk("rst_req_ready_b", 0, req_ready_b, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef SR_DRV_VERIFY_EN
        // Set with a slow latch: q_fb rises in the last guard cycle, the
        // synchroniser delivers it in VERIFY k=2, so done lands in cycle 9.
        run_req(1'b1, P + G + 3, 1'b0, 1'b0, P + G, 1'b1, 0);
        // Reset with a fast latch: q_fb follows in cycle 1, match at k=1.
        run_req(1'b0, DMIN, 1'b0, 1'b0, 1, 1'b0, 0);
        // Timeout: q_fb stuck at 1 while resetting.
        q_fb = 1'b1;
        run_req(1'b0, P + G + T + 1, 1'b1, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_sticky", i, err, 1'b1);
            chk("idle_ready", i, req_ready, 1'b1);
            chk("idle_done", i, done, 1'b0);
        end
        // Refresh set while the latch already reads 1; err clears on accept.
        run_req(1'b1, DMIN, 1'b0, 1'b0, 0, 1'b0, 0);
`else
        run_req(1'b1, DMIN, 1'b0, 1'b0, 0, 1'b0, 0);
        run_req(1'b0, DMIN, 1'b0, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_err", i, err, 1'b0);
            chk("idle_ready", i, req_ready, 1'b1);
            chk("idle_done", i, done, 1'b0);
        end
        run_req(1'b0, DMIN, 1'b0, 1'b0, 0, 1'b0, 0);
`endif

        // Back-to-back with alternating levels: each next accept happens in
        // the previous done cycle, checked by busy=1 in the following cycle 1.
        run_req(1'b1, DMIN, 1'b0, 1'b1, 1, 1'b1, 0);
        run_req(1'b0, DMIN, 1'b0, 1'b1, 1, 1'b0, 0);
        run_req(1'b1, DMIN, 1'b0, 1'b1, 1, 1'b1, 0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle_busy", 0, busy, 1'b0);
        chk("b2b_idle_done", 0, done, 1'b0);

        // Opposite-level request poked during PULSE cycle 2 must be ignored.
        run_req(1'b0, DMIN, 1'b0, 1'b0, 1, 1'b0, 2);
        @(negedge clk);
        chk("poke_idle_busy", 0, busy, 1'b0);
        chk("poke_idle_s", 0, s_out, 1'b0);
        chk("poke_idle_r", 0, r_out, 1'b0);

        // Reset in PULSE cycle 2: outputs drop without any clock edge.
        req_valid = 1'b1;
        req_level = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_s_before", 2, s_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_s_async", 2, s_out, 1'b0);
        chk("mid_r_async", 2, r_out, 1'b0);
        chk("mid_busy_async", 2, busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_ready", i, req_ready, 1'b1);
            chk("post_rst_done", i, done, 1'b0);
            chk("post_rst_err", i, err, 1'b0);
            chk("post_rst_s", i, s_out, 1'b0);
        end

        // PULSE_W=1, GUARD_W=1 instance
`ifdef SR_DRV_VERIFY_EN
        run_b(1'b0, DMIN_B);
`else
        run_b(1'b1, DMIN_B);
        run_b(1'b0, DMIN_B);
`endif
        @(negedge clk);
        chk("b_idle_ready", 0, req_ready_b, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
